// File: rtl/gmii_rx_framer_pkg.sv
// rtl/gmii_rx_framer_pkg.sv - shared constants, error bit indices and FSM states for the GMII receive framer
package gmii_rx_framer_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;

  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;

  localparam int RXERR_FCS   = 0;
  localparam int RXERR_ER    = 1;
  localparam int RXERR_RUNT  = 2;
  localparam int RXERR_GIANT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_t;

endpackage

// File: rtl/gmii_rx_framer_if.sv
// rtl/gmii_rx_framer_if.sv - GMII receive input and framed byte stream output of one port
interface gmii_rx_framer_if;

  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [3:0]  rx_err;
  logic [15:0] rx_len;

  // master is the framer: consumes GMII, sources the frame stream
  modport master (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_len
  );

  modport slave (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_len
  );

endinterface

// File: rtl/gmii_rx_framer_crc32_d8.sv
// rtl/gmii_rx_framer_crc32_d8.sv - combinational reflected CRC-32 update over one byte, LSB first
module gmii_rx_framer_crc32_d8
  import gmii_rx_framer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// rtl/gmii_rx_framer.sv - GMII receive framer: preamble/SFD strip, sof/eof delimiting, FCS and length checks, stats
module gmii_rx_framer
  import gmii_rx_framer_pkg::*;
#(
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter bit CHECK_FCS = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  gmii_rx_framer_if.master bus,
  output logic [31:0]      cnt_ok,
  output logic [31:0]      cnt_bad
);

  localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);
  localparam logic [15:0] GIANT_LEN = 16'(MAX_LEN + 1);

  rx_state_t   state;
  rx_state_t   state_nxt;

  logic [7:0]  hold_data;
  logic        hold_valid;
  logic        hold_first;
  logic [31:0] crc;
  logic [31:0] crc_nxt;
  logic [15:0] len;
  logic [15:0] len_inc;
  logic        er_seen;

  logic        is_pre;
  logic        is_sfd;
  logic        start_frame;
  logic        take_byte;
  logic        emit;
  logic        emit_eof;
  logic [3:0]  err_vec;

  assign is_pre  = (bus.gmii_rxd == ETH_PREAMBLE);
  assign is_sfd  = (bus.gmii_rxd == ETH_SFD);
  assign len_inc = len + 16'd1;

  gmii_rx_framer_crc32_d8 u_crc (
    .crc_in  (crc),
    .d       (bus.gmii_rxd),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.gmii_rx_dv) begin
          if (is_pre)      state_nxt = ST_PRE;
          else if (is_sfd) state_nxt = ST_DATA;
          else             state_nxt = ST_DROP;
        end
      end
      ST_PRE: begin
        if (!bus.gmii_rx_dv) state_nxt = ST_IDLE;
        else if (is_pre)     state_nxt = ST_PRE;
        else if (is_sfd)     state_nxt = ST_DATA;
        else                 state_nxt = ST_DROP;
      end
      ST_DATA: begin
        if (!bus.gmii_rx_dv)           state_nxt = ST_IDLE;
        else if (len_inc == GIANT_LEN) state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (!bus.gmii_rx_dv) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The hold register only stays full into DROP after a giant; that byte is
  // flushed there as the truncated frame's eof, so DROP+hold_valid means giant.
  always_comb begin
    start_frame = bus.gmii_rx_dv && is_sfd && (state == ST_IDLE || state == ST_PRE);
    take_byte   = bus.gmii_rx_dv && (state == ST_DATA);
    emit        = hold_valid && (state == ST_DATA || state == ST_DROP);
    emit_eof    = emit && (state == ST_DROP || !bus.gmii_rx_dv);
    err_vec                = 4'd0;
    err_vec[RXERR_GIANT]   = (state == ST_DROP);
    err_vec[RXERR_FCS]     = CHECK_FCS && (state != ST_DROP) && (crc != CRC32_RESIDUE);
    err_vec[RXERR_ER]      = er_seen;
    err_vec[RXERR_RUNT]    = (len < MIN_LEN16);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_data  <= 8'd0;
      hold_valid <= 1'b0;
      hold_first <= 1'b0;
      crc        <= CRC32_INIT;
      len        <= 16'd0;
      er_seen    <= 1'b0;
    end else if (start_frame) begin
      hold_valid <= 1'b0;
      hold_first <= 1'b0;
      crc        <= CRC32_INIT;
      len        <= 16'd0;
      er_seen    <= 1'b0;
    end else if (take_byte) begin
      hold_data  <= bus.gmii_rxd;
      hold_valid <= 1'b1;
      hold_first <= !hold_valid;
      crc        <= crc_nxt;
      len        <= len_inc;
      if (bus.gmii_rx_er) er_seen <= 1'b1;
    end else if (emit_eof) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bus.rx_data  <= 8'd0;
      bus.rx_valid <= 1'b0;
      bus.rx_sof   <= 1'b0;
      bus.rx_eof   <= 1'b0;
      bus.rx_err   <= 4'd0;
      bus.rx_len   <= 16'd0;
      cnt_ok       <= 32'd0;
      cnt_bad      <= 32'd0;
    end else begin
      bus.rx_valid <= emit;
      bus.rx_data  <= emit ? hold_data : 8'd0;
      bus.rx_sof   <= emit && hold_first;
      bus.rx_eof   <= emit_eof;
      bus.rx_err   <= emit_eof ? err_vec : 4'd0;
      bus.rx_len   <= emit_eof ? len : 16'd0;
      if (emit_eof) begin
        if (err_vec == 4'd0) cnt_ok  <= cnt_ok + 32'd1;
        else                 cnt_bad <= cnt_bad + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb/tb_gmii_rx_framer.sv - scoreboard bench for gmii_rx_framer with directed frames
module tb_gmii_rx_framer;

  typedef struct packed {
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic [3:0]  err;
    logic [15:0] len;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] cnt_ok;
  logic [31:0] cnt_bad;

  gmii_rx_framer_if bus ();

  gmii_rx_framer #(
    .MIN_LEN   (64),
    .MAX_LEN   (1518),
    .CHECK_FCS (1'b1)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus),
    .cnt_ok  (cnt_ok),
    .cnt_bad (cnt_bad)
  );

  initial forever #4 sys_clk = ~sys_clk;

  int         tests = 0;
  int         fails = 0;
  int         exp_ok = 0;
  int         exp_bad = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] frm[$];
  logic [7:0] raw[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] crc_add(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic build(input int n, input int seed, input bit add_fcs);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'((i * 13 + seed) & 255));
    if (add_fcs) begin
      c = 32'hFFFF_FFFF;
      foreach (frm[i]) c = crc_add(c, frm[i]);
      c = ~c;
      frm.push_back(c[7:0]);
      frm.push_back(c[15:8]);
      frm.push_back(c[23:16]);
      frm.push_back(c[31:24]);
    end
  endtask

  task automatic expect_frame(input int n_out, input logic [3:0] err, input int len, input bit ends);
    exp_t x;
    for (int i = 0; i < n_out; i++) begin
      x.d   = frm[i];
      x.sof = (i == 0);
      x.eof = ends && (i == n_out - 1);
      x.err = x.eof ? err : 4'd0;
      x.len = x.eof ? 16'(len) : 16'd0;
      exp_q.push_back(x);
    end
    if (ends) begin
      if (err == 4'd0) exp_ok++;
      else             exp_bad++;
    end
  endtask

  task automatic send(input int er_at, input int rst_on, input int rst_off, input int ifg);
    foreach (raw[j]) begin
      @(posedge sys_clk);
      #1;
      bus.gmii_rx_dv = 1'b1;
      bus.gmii_rxd   = raw[j];
      bus.gmii_rx_er = (j == er_at);
      if (j == rst_on)  sys_rst = 1'b1;
      if (j == rst_off) sys_rst = 1'b0;
    end
    @(posedge sys_clk);
    #1;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd   = 8'h00;
    repeat (ifg - 1) @(posedge sys_clk);
  endtask

  task automatic drive(input int npre, input int er_at, input int ifg, input int rst_on, input int rst_off);
    raw.delete();
    repeat (npre) raw.push_back(8'h55);
    raw.push_back(8'hD5);
    foreach (frm[i]) raw.push_back(frm[i]);
    send(er_at, rst_on, rst_off, ifg);
  endtask

  task automatic settle(input string name);
    repeat (6) @(posedge sys_clk);
    #1;
    chk({name, "_drain"},   64'(exp_q.size()), 64'd0);
    chk({name, "_cnt_ok"},  64'(cnt_ok),       64'(exp_ok));
    chk({name, "_cnt_bad"}, 64'(cnt_bad),      64'(exp_bad));
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      chk("reset_outputs", 64'({bus.rx_valid, bus.rx_sof, bus.rx_eof, bus.rx_err, bus.rx_len, bus.rx_data}), 64'd0);
      chk("reset_counters", {cnt_ok, cnt_bad}, 64'd0);
    end else if (bus.rx_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got data %0h sof %0b eof %0b, expected no output", bus.rx_data, bus.rx_sof, bus.rx_eof);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_byte", 64'({bus.rx_data, bus.rx_sof, bus.rx_eof, bus.rx_err, bus.rx_len}), 64'(mon_e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.gmii_rxd   = 8'h00;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    sys_rst        = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("idle_valid", 64'(bus.rx_valid), 64'd0);
    chk("idle_counters", {cnt_ok, cnt_bad}, 64'd0);

    // 64-byte good frame behind a 7-byte preamble
    build(60, 8'h10, 1'b1);
    expect_frame(64, 4'b0000, 64, 1'b1);
    drive(7, -1, 12, -1, -1);
    settle("t1_good64");

    // corrupted last FCS byte
    build(60, 8'h10, 1'b1);
    frm[63] = frm[63] ^ 8'h01;
    expect_frame(64, 4'b0001, 64, 1'b1);
    drive(7, -1, 12, -1, -1);
    settle("t2_fcs_bad");

    // runt with good FCS, then a single-byte frame
    build(36, 8'h30, 1'b1);
    expect_frame(40, 4'b0100, 40, 1'b1);
    drive(7, -1, 12, -1, -1);
    settle("t3_runt40");
    build(1, 8'h42, 1'b0);
    expect_frame(1, 4'b0101, 1, 1'b1);
    drive(7, -1, 12, -1, -1);
    settle("t3_one_byte");

    // giant truncated at 1519 bytes, then a good frame
    build(1596, 8'h07, 1'b1);
    expect_frame(1519, 4'b1000, 1519, 1'b1);
    drive(7, -1, 12, -1, -1);
    settle("t4_giant");
    build(60, 8'h5A, 1'b1);
    expect_frame(64, 4'b0000, 64, 1'b1);
    drive(7, -1, 12, -1, -1);
    settle("t4_after_giant");

    // rx_er on payload byte 10
    build(60, 8'h60, 1'b1);
    expect_frame(64, 4'b0010, 64, 1'b1);
    drive(7, 7 + 1 + 10, 12, -1, -1);
    settle("t5_rx_er");

    // bad preamble goes to DROP; SFD/preamble bytes and rx_er inside are ignored
    raw = '{8'h55, 8'h55, 8'hAA};
    for (int i = 0; i < 20; i++) raw.push_back((i % 3 == 0) ? 8'hD5 : 8'h55);
    send(6, -1, -1, 12);
    settle("t5_drop");

    // SFD immediately followed by dv low
    raw = '{8'h55, 8'h55, 8'hD5};
    send(-1, -1, -1, 12);
    settle("t5_sfd_only");

    // rx_er during preamble is ignored
    build(60, 8'h77, 1'b1);
    expect_frame(64, 4'b0000, 64, 1'b1);
    drive(3, 1, 12, -1, -1);
    settle("t5_er_in_pre");

    // no preamble, then back-to-back frames with a single idle cycle
    build(60, 8'h91, 1'b1);
    expect_frame(64, 4'b0000, 64, 1'b1);
    drive(0, -1, 1, -1, -1);
    build(60, 8'hA3, 1'b1);
    expect_frame(64, 4'b0000, 64, 1'b1);
    drive(7, -1, 12, -1, -1);
    settle("t5_back_to_back");

    // reset during payload byte 30..40; frm[0..27] leave before reset hits
    build(60, 8'h21, 1'b1);
    expect_frame(28, 4'b0000, 0, 1'b0);
    exp_ok  = 0;
    exp_bad = 0;
    drive(7, -1, 12, 7 + 1 + 30, 7 + 1 + 40);
    settle("t6_reset_mid");
    build(60, 8'h3C, 1'b1);
    expect_frame(64, 4'b0000, 64, 1'b1);
    drive(7, -1, 12, -1, -1);
    settle("t6_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
